// File: rtl/ssds_scan_controller_if.sv
// Connection bundle between the SSD bus peripheral and the seven-segment scan controller.
// master = peripheral side (drives patterns/enable), slave = scan controller.
interface ssds_scan_controller_if #(
  parameter int unsigned BRIGHT_BITS = 4
) ();

  logic                   en;
  logic [6:0]             digit_0;
  logic [6:0]             digit_1;
  logic [6:0]             digit_2;
  logic [6:0]             digit_3;
  logic [3:0]             dots;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [6:0]             seg_out;
  logic                   dot_out;
  logic [3:0]             digit_sel;
  logic                   frame_tick;

  modport master (
    output en, digit_0, digit_1, digit_2, digit_3, dots, brightness,
    input  seg_out, dot_out, digit_sel, frame_tick
  );

  modport slave (
    input  en, digit_0, digit_1, digit_2, digit_3, dots, brightness,
    output seg_out, dot_out, digit_sel, frame_tick
  );

endinterface

// File: rtl/ssds_scan_controller.sv
// Time-multiplexed 4-digit seven-segment scan driver with inter-digit blanking,
// PWM brightness and a per-frame tick. All display outputs are registered.
module ssds_scan_controller #(
  parameter int unsigned DIGIT_CYCLES     = 12500,
  parameter int unsigned BLANK_CYCLES     = 250,
  parameter int unsigned BRIGHT_BITS      = 4,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ssds_scan_controller_if.slave bus
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]       BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [BRIGHT_BITS-1:0] DUTY_FULL  = '1;
  localparam logic [6:0]             SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                   DOT_OFF    = SEG_ACTIVE_LOW;
  localparam logic [3:0]             SEL_OFF    = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
  logic [BRIGHT_BITS-1:0] duty_q, duty_d;
  logic [6:0]             shadow_seg_q, shadow_seg_d;
  logic                   shadow_dot_q, shadow_dot_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dot_q, dot_d;
  logic [3:0]             sel_q, sel_d;
  logic                   tick_q, tick_d;

  logic [6:0]             cur_seg_c;
  logic                   cur_dot_c;
  logic                   lit_c;
  logic [3:0]             sel_onehot_c;

  // Pattern of the digit owning the current slot, captured on entry to ON.
  always_comb begin
    cur_seg_c = bus.digit_0;
    unique case (idx_q)
      2'd0: cur_seg_c = bus.digit_0;
      2'd1: cur_seg_c = bus.digit_1;
      2'd2: cur_seg_c = bus.digit_2;
      2'd3: cur_seg_c = bus.digit_3;
      default: cur_seg_c = bus.digit_0;
    endcase
    cur_dot_c = bus.dots[idx_q];
  end

  // Full duty bypasses the comparison so all-ones is continuously on.
  assign lit_c        = (state_q == ST_ON) && ((duty_q == DUTY_FULL) || (pwm_q < duty_q));
  assign sel_onehot_c = 4'(4'b0001 << idx_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pwm_d        = pwm_q;
    duty_d       = duty_q;
    shadow_seg_d = shadow_seg_q;
    shadow_dot_d = shadow_dot_q;
    seg_d        = SEG_OFF;
    dot_d        = DOT_OFF;
    sel_d        = SEL_OFF;
    tick_d       = 1'b0;

    if (!bus.en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
      pwm_d   = '0;
    end else begin
      if (lit_c) begin
        seg_d = SEG_ACTIVE_LOW ? ~shadow_seg_q : shadow_seg_q;
        dot_d = SEG_ACTIVE_LOW ? ~shadow_dot_q : shadow_dot_q;
        sel_d = DIGIT_ACTIVE_LOW ? ~sel_onehot_c : sel_onehot_c;
      end

      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + 2'd1;
        tick_d = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d      = ST_ON;
            shadow_seg_d = cur_seg_c;
            shadow_dot_d = cur_dot_c;
            duty_d       = BRIGHT_BITS'(bus.brightness);
            pwm_d        = '0;
          end
        end
        ST_ON: begin
          pwm_d = pwm_q + BRIGHT_BITS'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      duty_q       <= '0;
      shadow_seg_q <= '0;
      shadow_dot_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dot_q        <= DOT_OFF;
      sel_q        <= SEL_OFF;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      duty_q       <= duty_d;
      shadow_seg_q <= shadow_seg_d;
      shadow_dot_q <= shadow_dot_d;
      seg_q        <= seg_d;
      dot_q        <= dot_d;
      sel_q        <= sel_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dot_out    = dot_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_ssds_scan_controller.sv
// Randomized self-checking bench for ssds_scan_controller against a slot/phase timing model.
module tb_ssds_scan_controller;

  localparam int DC = 16;
  localparam int BC = 4;
  localparam int BB = 2;
  localparam int FRAME = 4 * DC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] dg [4];

  ssds_scan_controller_if #(.BRIGHT_BITS(BB)) bus ();

  ssds_scan_controller #(
    .DIGIT_CYCLES    (DC),
    .BLANK_CYCLES    (BC),
    .BRIGHT_BITS     (BB),
    .SEG_ACTIVE_LOW  (1'b1),
    .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.digit_0 = dg[0];
  assign bus.digit_1 = dg[1];
  assign bus.digit_2 = dg[2];
  assign bus.digit_3 = dg[3];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: time since restart gives slot, digit and phase directly.
  int         m_t = 0;
  logic [6:0] m_seg = '0;
  logic       m_dot = 1'b0;
  logic [1:0] m_duty = '0;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dot = 1'b1;
  logic [3:0] exp_sel = 4'hF;
  logic       exp_tick = 1'b0;

  function automatic bit ref_lit(input int t, input logic [1:0] duty);
    int ph;
    ph = t % DC;
    if (ph < BC) return 1'b0;
    if (duty == 2'd3) return 1'b1;
    return ((ph - BC) % (1 << BB)) < int'(duty);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || !bus.en) begin
      m_t      <= 0;
      exp_seg  <= 7'h7F;
      exp_dot  <= 1'b1;
      exp_sel  <= 4'hF;
      exp_tick <= 1'b0;
    end else begin
      if (ref_lit(m_t, m_duty)) begin
        exp_seg <= ~m_seg;
        exp_dot <= ~m_dot;
        exp_sel <= ~(4'b0001 << ((m_t / DC) % 4));
      end else begin
        exp_seg <= 7'h7F;
        exp_dot <= 1'b1;
        exp_sel <= 4'hF;
      end
      exp_tick <= ((m_t % FRAME) == FRAME - 1);
      if ((m_t % DC) == BC - 1) begin
        m_seg  <= dg[(m_t / DC) % 4];
        m_dot  <= bus.dots[(m_t / DC) % 4];
        m_duty <= bus.brightness;
      end
      m_t <= m_t + 1;
    end
  end

  // Every cycle: outputs against the model, and never more than one digit selected.
  always @(negedge clk) begin
    check_eq("seg_out", 32'(bus.seg_out), 32'(exp_seg));
    check_eq("dot_out", 32'(bus.dot_out), 32'(exp_dot));
    check_eq("digit_sel", 32'(bus.digit_sel), 32'(exp_sel));
    check_eq("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
    check_eq("sel_onehot", 32'($countones(~bus.digit_sel) <= 1), 32'd1);
  end

  task automatic wait_phase(input int dig, input int ph);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((m_t % DC) == ph && (dig < 0 || ((m_t / DC) % 4) == dig)) return;
    end
    check_eq("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_first_lit(input int expn);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.digit_sel == 4'hF && n < 40);
    check_eq("first_lit_cycle", 32'(n), 32'(expn));
  endtask

  task automatic wait_tick(input string tag, input int expn);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 200);
    check_eq(tag, 32'(n), 32'(expn));
  endtask

  task automatic count_lit_slot(input logic [1:0] br, input int expn);
    int lit;
    lit = 0;
    bus.brightness = br;
    wait_phase(-1, 0);
    wait_phase(-1, 1);
    for (int i = 0; i < DC; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.digit_sel != 4'hF) lit++;
    end
    check_eq("lit_count", 32'(lit), 32'(expn));
  endtask

  initial begin
    bus.en = 1'b0;
    bus.dots = '0;
    bus.brightness = '0;
    for (int i = 0; i < 4; i++) dg[i] = 7'($urandom);

    // Held in reset with random inputs: outputs must stay dark.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.en = 1'($urandom);
      bus.dots = 4'($urandom);
      bus.brightness = BB'($urandom);
      for (int k = 0; k < 4; k++) dg[k] = 7'($urandom);
    end
    check_eq("rst_sel", 32'(bus.digit_sel), 32'h0F);
    check_eq("rst_seg", 32'(bus.seg_out), 32'h7F);

    // Full brightness scan.
    bus.en = 1'b1;
    bus.brightness = 2'd3;
    dg[0] = 7'h3F;
    dg[1] = 7'h06;
    bus.dots = 4'b0001;
    rst = 1'b1;
    wait_first_lit(BC + 1);
    check_eq("d0_seg", 32'(bus.seg_out), 32'h40);
    check_eq("d0_dot", 32'(bus.dot_out), 32'd0);
    check_eq("d0_sel", 32'(bus.digit_sel), 32'hE);
    wait_tick("first_tick_gap", FRAME - (BC + 1));
    wait_tick("tick_period", FRAME);

    // Pattern change mid-ON is ignored for the current slot.
    wait_phase(1, 8);
    check_eq("d1_seg", 32'(bus.seg_out), 32'h79);
    check_eq("d1_dot", 32'(bus.dot_out), 32'd1);
    dg[1] = 7'h5B;
    @(negedge clk);
    check_eq("d1_hold", 32'(bus.seg_out), 32'h79);
    wait_phase(1, 8);
    check_eq("d1_new", 32'(bus.seg_out), 32'h24);

    // PWM duty per slot.
    count_lit_slot(2'd1, 3);
    count_lit_slot(2'd0, 0);
    count_lit_slot(2'd2, 6);
    count_lit_slot(2'd3, DC - BC);

    // Enable drop mid-ON, then restart from digit 0.
    wait_phase(2, 8);
    bus.en = 1'b0;
    @(negedge clk);
    check_eq("en_off_sel", 32'(bus.digit_sel), 32'hF);
    check_eq("en_off_seg", 32'(bus.seg_out), 32'h7F);
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    wait_first_lit(BC + 1);
    check_eq("reen_sel", 32'(bus.digit_sel), 32'hE);
    wait_tick("reen_tick_gap", FRAME - (BC + 1));

    // Short asynchronous reset pulse mid-ON.
    wait_phase(1, 8);
    #1 rst = 1'b0;
    #1;
    check_eq("arst_sel", 32'(bus.digit_sel), 32'hF);
    check_eq("arst_seg", 32'(bus.seg_out), 32'h7F);
    check_eq("arst_dot", 32'(bus.dot_out), 32'd1);
    check_eq("arst_tick", 32'(bus.frame_tick), 32'd0);
    #2 rst = 1'b1;
    wait_first_lit(BC + 1);
    check_eq("arst_restart_sel", 32'(bus.digit_sel), 32'hE);

    // Random traffic, including occasional enable drops.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) dg[$urandom_range(0, 3)] = 7'($urandom);
      if ($urandom_range(0, 15) == 0) bus.dots = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.brightness = BB'($urandom);
      if (bus.en) begin
        if ($urandom_range(0, 299) == 0) bus.en = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.en = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
